led_display_driver: RTL and testbench

LED_DISPLAY_DRIVER -- requirements
Module: led_display_driver

---
 rtl/led_display_driver.sv | 158 +++++++++++++++
 tb/tb_led_display_driver.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/led_display_driver.sv
// LED display driver: selects a 10-LED pattern (binary, thermometer, scan or
// off), gates it with a frame-based PWM brightness signal and registers the
// result onto the LED pins. Brightness and mode are captured only at frame
// boundaries so a frame is never drawn with a mixture of settings.
module led_display_driver #(
    parameter int PWM_BITS = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [9:0]          value,
    input  logic                value_valid,
    input  logic [1:0]          mode,
    input  logic [PWM_BITS-1:0] duty,
    output logic [9:0]          led,
    output logic                frame_done
);

    typedef enum logic [1:0] {
        SCAN_UP   = 2'b00,
        SCAN_DOWN = 2'b01
    } scan_state_t;

    localparam logic [1:0]          MODE_BINARY  = 2'd0;
    localparam logic [1:0]          MODE_THERMO  = 2'd1;
    localparam logic [1:0]          MODE_SCAN    = 2'd2;
    localparam logic [PWM_BITS-1:0] PWM_MAX      = '1;
    localparam logic [3:0]          POS_LAST     = 4'd9;

    logic [PWM_BITS-1:0] pwm_cnt;
    logic [PWM_BITS-1:0] duty_reg;
    logic [1:0]          mode_reg;
    logic [9:0]          value_reg;
    logic [3:0]          pos;
    logic [3:0]          pos_next;
    scan_state_t         state;
    scan_state_t         state_next;
    logic                frame_bound;
    logic                pwm_on;
    logic                scan_step;
    logic [9:0]          pattern;
    logic [9:0]          thermo_pat;

    assign frame_bound = (pwm_cnt == PWM_MAX);
    assign pwm_on      = (pwm_cnt < duty_reg);
    assign scan_step   = value_valid && (mode_reg == MODE_SCAN);

    // Free-running PWM counter that defines the frame period.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pwm_cnt <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + 1'b1;
        end
    end

    // Capture brightness and mode at the frame boundary and flag the new frame.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            duty_reg   <= '0;
            mode_reg   <= MODE_BINARY;
            frame_done <= 1'b0;
        end else begin
            frame_done <= frame_bound;
            if (frame_bound) begin
                duty_reg <= duty;
                mode_reg <= mode;
            end
        end
    end

    // Latch each new upstream value whatever mode is showing.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            value_reg <= '0;
        end else if (value_valid) begin
            value_reg <= value;
        end
    end

    // Scan position and direction registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= SCAN_UP;
            pos   <= '0;
        end else begin
            state <= state_next;
            pos   <= pos_next;
        end
    end

    // Bounce the scan position between 0 and 9; corrupted state restarts at 0.
    always_comb begin
        state_next = state;
        pos_next   = pos;
        case (state)
            SCAN_UP: begin
                if (pos > POS_LAST) begin
                    state_next = SCAN_UP;
                    pos_next   = '0;
                end else if (scan_step) begin
                    if (pos == POS_LAST) begin
                        state_next = SCAN_DOWN;
                        pos_next   = POS_LAST - 4'd1;
                    end else begin
                        pos_next   = pos + 4'd1;
                    end
                end
            end
            SCAN_DOWN: begin
                if (pos > POS_LAST) begin
                    state_next = SCAN_UP;
                    pos_next   = '0;
                end else if (scan_step) begin
                    if (pos == 4'd0) begin
                        state_next = SCAN_UP;
                        pos_next   = 4'd1;
                    end else begin
                        pos_next   = pos - 4'd1;
                    end
                end
            end
            default: begin
                state_next = SCAN_UP;
                pos_next   = '0;
            end
        endcase
    end

    // Thermometer bar: LED i lights when the top nibble exceeds i, so values
    // of ten or more naturally saturate to a full bar.
    always_comb begin
        thermo_pat = '0;
        for (int i = 0; i < 10; i++) begin
            thermo_pat[i] = (4'(i) < value_reg[9:6]);
        end
    end

    // Choose the pattern for the mode captured at the last frame boundary.
    always_comb begin
        pattern = '0;
        case (mode_reg)
            MODE_BINARY: pattern = value_reg;
            MODE_THERMO: pattern = thermo_pat;
            MODE_SCAN:   pattern = 10'(1) << pos;
            default:     pattern = '0;
        endcase
    end

    // Register the PWM-gated pattern onto the LED pins.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            led <= '0;
        end else begin
            led <= pattern & {10{pwm_on}};
        end
    end

endmodule

// File: tb/tb_led_display_driver.sv
// Directed testbench for led_display_driver: walks through reset, PWM duty
// extremes, each display mode, frame-aligned mode changes, the scan bounce
// and an asynchronous reset in the middle of a scan.
module tb_led_display_driver;

    logic       clk;
    logic       reset;
    logic [9:0] value;
    logic       value_valid;
    logic [1:0] mode;
    logic [7:0] duty;
    logic [9:0] led;
    logic       frame_done;

    int assertions;
    int failures;
    int cyc;

    led_display_driver #(.PWM_BITS(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .value       (value),
        .value_valid (value_valid),
        .mode        (mode),
        .duty        (duty),
        .led         (led),
        .frame_done  (frame_done)
    );

    // 10 ns system clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        assertions++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic stepTo(input int target);
        while (cyc < target) step(1);
    endtask

    task automatic applyStimulus(input logic [9:0] v);
        value       = v;
        value_valid = 1'b1;
        step(1);
        value_valid = 1'b0;
    endtask

    // Called just after a frame boundary; samples one whole frame of LEDs.
    task automatic measureFrame(input string tag, input logic [9:0] pat, input int exp_lit);
        int lit;
        int bad;
        lit = 0;
        bad = 0;
        for (int i = 0; i < 256; i++) begin
            step(1);
            if (led != 10'd0) begin
                lit++;
                if (led != pat) bad++;
            end
        end
        checkOutput({tag, "_lit"}, lit, exp_lit);
        checkOutput({tag, "_pattern"}, bad, 0);
        checkOutput({tag, "_frame_done"}, frame_done, 1'b1);
    endtask

    initial begin
        int exp_pos [20] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 8, 7, 6, 5, 4, 3, 2, 1, 0, 1, 2};
        assertions  = 0;
        failures    = 0;
        cyc         = 0;
        reset       = 1'b0;
        value       = 10'h2A5;
        value_valid = 1'b0;
        mode        = 2'd0;
        duty        = 8'd128;

        step(3);
        checkOutput("reset_led", led, 10'd0);
        checkOutput("reset_frame_done", frame_done, 1'b0);

        reset = 1'b1;
        cyc   = 0;
        applyStimulus(10'h2A5);
        checkOutput("first_frame_dark", led, 10'd0);
        stepTo(255);
        checkOutput("no_early_frame_done", frame_done, 1'b0);
        step(1);
        checkOutput("first_frame_done", frame_done, 1'b1);
        checkOutput("boundary_cycle_dark", led, 10'd0);
        step(1);
        checkOutput("duty128_lit", led, 10'h2A5);
        checkOutput("frame_done_one_cycle", frame_done, 1'b0);
        stepTo(384);
        checkOutput("duty128_last_lit", led, 10'h2A5);
        step(1);
        checkOutput("duty128_first_dark", led, 10'd0);
        stepTo(512);
        checkOutput("second_frame_done", frame_done, 1'b1);

        duty = 8'd0;
        measureFrame("duty128", 10'h2A5, 128);
        duty = 8'd255;
        measureFrame("duty0", 10'h2A5, 0);
        measureFrame("duty255", 10'h2A5, 255);

        mode = 2'd1;
        stepTo(1536);
        applyStimulus({4'd3, 6'h2A});
        step(1);
        checkOutput("thermo_3", led, 10'b0000000111);
        applyStimulus({4'd15, 6'h00});
        step(1);
        checkOutput("thermo_15", led, 10'h3FF);
        applyStimulus({4'd0, 6'h3F});
        step(1);
        checkOutput("thermo_0", led, 10'h000);
        applyStimulus({4'd9, 6'h00});
        step(1);
        checkOutput("thermo_9", led, 10'h1FF);
        applyStimulus({4'd10, 6'h00});
        step(1);
        checkOutput("thermo_10", led, 10'h3FF);

        mode = 2'd0;
        applyStimulus(10'h155);
        stepTo(1792);
        step(1);
        checkOutput("binary_155", led, 10'h155);
        stepTo(1900);
        mode = 2'd2;
        step(1);
        checkOutput("mode_change_midframe", led, 10'h155);
        stepTo(1950);
        applyStimulus(10'h155);
        stepTo(2047);
        checkOutput("mode_held_until_boundary", led, 10'h155);
        step(1);
        checkOutput("boundary_dark_255", led, 10'd0);
        step(1);
        checkOutput("scan_start_pos0", led, 10'h001);

        for (int i = 0; i < 20; i++) begin
            applyStimulus(10'(i));
            step(1);
            checkOutput($sformatf("scan_step%0d", i), led, 10'(1) << exp_pos[i]);
        end

        mode = 2'd3;
        stepTo(2304);
        step(1);
        checkOutput("mode3_off", led, 10'd0);
        mode = 2'd2;
        stepTo(2310);
        applyStimulus(10'h000);
        stepTo(2560);
        step(1);
        checkOutput("scan_resume_pos2", led, 10'h004);
        applyStimulus(10'h000);
        step(1);
        checkOutput("scan_resume_up", led, 10'h008);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(10'h000);
            step(1);
        end
        checkOutput("scan_pos6", led, 10'h040);

        reset = 1'b0;
        #1;
        checkOutput("async_reset_led", led, 10'd0);
        checkOutput("async_reset_frame_done", frame_done, 1'b0);
        step(2);
        checkOutput("held_reset_led", led, 10'd0);
        reset = 1'b1;
        cyc   = 0;
        stepTo(255);
        checkOutput("post_reset_no_frame_done", frame_done, 1'b0);
        checkOutput("post_reset_dark", led, 10'd0);
        step(1);
        checkOutput("post_reset_frame_done", frame_done, 1'b1);
        applyStimulus(10'h000);
        step(1);
        checkOutput("post_reset_scan_pos1", led, 10'h002);

        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
